// File: rtl/bsg_histo_counter_array.sv
// bsg_histo_counter_array
//   Multi-channel histogram counter array. Each channel sorts an unsigned
//   sample stream into els_p ranged bins plus an underflow bin (index els_p)
//   and an overflow bin (index els_p+1). Every counter saturates.
//   A registered random-access read port and a swept clear FSM let monitors
//   dump and reset the histograms without hierarchical access.
//
//   Optional feature (macro BSG_HISTO_TOTAL_EN): adds a per-channel saturating
//   total-sample counter. It is read at bin els_p+2 and is zeroed as the last
//   sweep step. Without the macro, bin els_p+2 reads 0.
//
// Ports
//   clk_i, reset_i   : clock, synchronous active-high reset
//   v_i, val_i       : per-channel sample valid / sample (channel k at k*val_width_p)
//   clear_i          : pulse, starts (or restarts) a clear sweep
//   clear_busy_o     : sweep in progress
//   rd_v_i, rd_ch_i, rd_bin_i : read request
//   rd_v_o, rd_data_o : read response, one cycle after the request
//   drop_count_o     : saturating count of samples dropped during clears

// Per-channel lane: bin computation (stage 1) and counter storage (stage 2).
module bsg_histo_counter_array_lane
  #(parameter int val_width_p = 16
  , parameter int els_p       = 16
  , parameter int start_p     = 0
  , parameter int bin_shift_p = 0
  , parameter int ctr_width_p = 32
  , parameter int nb_p        = 18
  , parameter int bin_w_p     = 5
  , parameter bit total_p     = 1'b0)
  (input  logic                   clk_i
  ,input  logic                   reset_i
  ,input  logic                   v_i        // already qualified against clears
  ,input  logic [val_width_p-1:0] val_i
  ,input  logic                   clr_v_i
  ,input  logic [bin_w_p-1:0]     clr_idx_i
  ,input  logic [bin_w_p-1:0]     rd_bin_i
  ,output logic [ctr_width_p-1:0] rd_data_o);

  localparam int DW = val_width_p + 1;

  logic [DW-1:0]      d, d_sh;
  logic [bin_w_p-1:0] bin_n, bin_r;
  logic               v_r;

  // One extra bit so val_i - start_p never wraps silently.
  always_comb begin
    d    = {1'b0, val_i} - DW'(start_p);
    d_sh = d >> bin_shift_p;
    if ({1'b0, val_i} < DW'(start_p))  bin_n = bin_w_p'(els_p);
    else if (d_sh >= DW'(els_p))       bin_n = bin_w_p'(els_p + 1);
    else                               bin_n = bin_w_p'(d_sh);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_r   <= 1'b0;
      bin_r <= '0;
    end else begin
      v_r   <= v_i;
      bin_r <= bin_n;
    end
  end

  logic [nb_p-1:0][ctr_width_p-1:0] cnt;

  // Sweep zeroing and stage-2 increments never target the same cycle
  // (samples are dropped while a clear is pending or active), so the
  // priority order below only matters for reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < nb_p; b++) begin
      if (reset_i)
        cnt[b] <= '0;
      else if (clr_v_i && clr_idx_i == bin_w_p'(b))
        cnt[b] <= '0;
      else if (v_r && (bin_r == bin_w_p'(b) || (total_p && b == nb_p-1)) && !(&cnt[b]))
        cnt[b] <= cnt[b] + ctr_width_p'(1);
    end
  end

  // Indices past the last built counter read 0.
  always_comb begin
    rd_data_o = '0;
    for (int b = 0; b < nb_p; b++)
      if (rd_bin_i == bin_w_p'(b)) rd_data_o = cnt[b];
  end

endmodule

module bsg_histo_counter_array
  #(parameter int channels_p  = 2
  , parameter int val_width_p = 16
  , parameter int els_p       = 16
  , parameter int start_p     = 0
  , parameter int bin_shift_p = 0
  , parameter int ctr_width_p = 32)
  (input  logic                                          clk_i
  ,input  logic                                          reset_i
  ,input  logic [channels_p-1:0]                         v_i
  ,input  logic [channels_p*val_width_p-1:0]             val_i
  ,input  logic                                          clear_i
  ,output logic                                          clear_busy_o
  ,input  logic                                          rd_v_i
  ,input  logic [((channels_p > 1) ? $clog2(channels_p) : 1)-1:0] rd_ch_i
  ,input  logic [$clog2(els_p+3)-1:0]                    rd_bin_i
  ,output logic                                          rd_v_o
  ,output logic [ctr_width_p-1:0]                        rd_data_o
  ,output logic [ctr_width_p-1:0]                        drop_count_o);

`ifdef BSG_HISTO_TOTAL_EN
  localparam bit TOTAL = 1'b1;
`else
  localparam bit TOTAL = 1'b0;
`endif
  localparam int NB = els_p + 2 + (TOTAL ? 1 : 0);
  localparam int BW = $clog2(els_p + 3);
  localparam int CW = (channels_p > 1) ? $clog2(channels_p) : 1;
  localparam int SW = ctr_width_p + 1;

  typedef enum logic {IDLE_S, SWEEP_S} state_e;

  state_e          state;
  logic [BW-1:0]   sweep_idx;
  logic            drop_win;
  logic [channels_p-1:0] v_acc;

  assign drop_win = clear_i | clear_busy_o;
  assign v_acc    = v_i & {channels_p{~drop_win}};

  // Clear FSM; clear_busy_o is registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= IDLE_S;
      sweep_idx    <= '0;
      clear_busy_o <= 1'b0;
    end else begin
      case (state)
        IDLE_S: if (clear_i) begin
          state        <= SWEEP_S;
          sweep_idx    <= '0;
          clear_busy_o <= 1'b1;
        end
        SWEEP_S: begin
          if (clear_i) begin
            sweep_idx <= '0;
          end else if (sweep_idx == BW'(NB-1)) begin
            state        <= IDLE_S;
            sweep_idx    <= '0;
            clear_busy_o <= 1'b0;
          end else begin
            sweep_idx <= sweep_idx + BW'(1);
          end
        end
        default: begin
          state        <= IDLE_S;
          clear_busy_o <= 1'b0;
        end
      endcase
    end
  end

  logic [channels_p-1:0][ctr_width_p-1:0] lane_data;

  for (genvar k = 0; k < channels_p; k++) begin : lane
    bsg_histo_counter_array_lane
      #(.val_width_p(val_width_p), .els_p(els_p), .start_p(start_p)
       ,.bin_shift_p(bin_shift_p), .ctr_width_p(ctr_width_p)
       ,.nb_p(NB), .bin_w_p(BW), .total_p(TOTAL))
      u_lane
      (.clk_i     (clk_i)
      ,.reset_i   (reset_i)
      ,.v_i       (v_acc[k])
      ,.val_i     (val_i[k*val_width_p +: val_width_p])
      ,.clr_v_i   (clear_busy_o)
      ,.clr_idx_i (sweep_idx)
      ,.rd_bin_i  (rd_bin_i)
      ,.rd_data_o (lane_data[k]));
  end

  logic [ctr_width_p-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < channels_p; c++)
      if (rd_ch_i == CW'(c)) rd_mux = lane_data[c];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_v_o    <= 1'b0;
      rd_data_o <= '0;
    end else begin
      rd_v_o <= rd_v_i;
      if (rd_v_i) rd_data_o <= clear_busy_o ? '0 : rd_mux;
    end
  end

  // Drop counter: popcount of valid samples seen while a clear is pending or active.
  logic [SW-1:0] drop_sum;
  assign drop_sum = {1'b0, drop_count_o} + SW'($countones(v_i));

  always_ff @(posedge clk_i) begin
    if (reset_i)
      drop_count_o <= '0;
    else if (drop_win && |v_i)
      drop_count_o <= drop_sum[ctr_width_p] ? '1 : drop_sum[ctr_width_p-1:0];
  end

endmodule

// File: doc/bsg_histo_counter_array.md
Name: bsg_histo_counter_array

Overview:
- Synthesizable multi-channel histogram counter array; the next generation of the non-synthesizable per-instance histogram profiler client.
- Each channel bins an unsigned sample stream into els_p ranged bins plus an underflow bin and an overflow bin, all with saturating counters.
- Exposes a registered random-access readout port and a swept clear state machine, so hardware monitors and testbenches can dump and reset histograms without hierarchical access.

Parameters:
- channels_p, 2: number of independent sample channels.
- val_width_p, 16: width of each sample value (unsigned).
- els_p, 16: number of ranged bins per channel.
- start_p, 0: lowest value counted in bin 0.
- bin_shift_p, 0: each bin spans 2^bin_shift_p consecutive values.
- ctr_width_p, 32: width of every counter; counters saturate.

Ports:
- clk_i, input, 1: clock.
- reset_i, input, 1: synchronous, active-high reset.
- v_i, input, channels_p: per-channel sample valid.
- val_i, input, channels_p*val_width_p: samples; channel k is at bits [k*val_width_p +: val_width_p].
- clear_i, input, 1: pulse; starts a clear sweep.
- clear_busy_o, output, 1: sweep in progress.
- rd_v_i, input, 1: read request.
- rd_ch_i, input, clog2(channels_p) (safe): read channel.
- rd_bin_i, input, clog2(els_p+3): read bin index.
- rd_v_o, output, 1: read data valid.
- rd_data_o, output, ctr_width_p: read data.
- drop_count_o, output, ctr_width_p: samples dropped during clear.

Behaviour:
- Clock and reset: one clock. reset is synchronous and active-high.
- Reset: all counters = 0; state = IDLE; clear_busy_o = 0; rd_v_o = 0; rd_data_o = 0; drop_count_o = 0.
- Bin mapping, per channel:
  - d = val_i - start_p, computed unsigned in val_width_p+1 bits.
  - If val_i < start_p: underflow bin, index els_p.
  - Else if (d >> bin_shift_p) >= els_p: overflow bin, index els_p+1.
  - Else: bin index d >> bin_shift_p.
- Pipeline:
  - Stage 1 registers the channel valid and the computed bin index.
  - Stage 2 increments the selected counter.
  - v_i in cycle N lands at the edge ending cycle N+1, so it is visible to reads issued in cycle N+2 and later.
  - Channels are fully independent; all channels may increment in the same cycle.
- Saturation: a counter at 2^ctr_width_p-1 holds its value; it never wraps.
- Read:
  - rd_v_i in cycle M samples counter storage as it stands during cycle M.
  - rd_v_o = 1 and rd_data_o are valid in cycle M+1.
  - rd_v_o = 0 when no read was issued; rd_data_o holds its last value.
  - An out-of-range rd_ch_i or rd_bin_i returns 0 with rd_v_o = 1.
  - A read while clear_busy_o = 1 returns 0.
  - Back-to-back reads sustain one per cycle.
- Clear FSM, states IDLE and SWEEP:
  - IDLE to SWEEP on clear_i, with sweep index = 0.
  - In SWEEP, bin[sweep index] is zeroed in every channel each cycle; the index increments.
  - After bin els_p+1 (and the total bin, if enabled) is zeroed, return to IDLE.
  - clear_busy_o = 1 exactly while in SWEEP: els_p+2 cycles, starting the cycle after clear_i.
  - clear_i asserted during SWEEP restarts the sweep at index 0.
- Drops:
  - A v_i sampled while clear_i = 1 or clear_busy_o = 1 is dropped, never counted.
  - Each dropped valid channel-sample adds 1 to drop_count_o; several channels in one cycle add their popcount.
  - drop_count_o saturates and is cleared only by reset.
  - Consequently no stage-2 write ever overlaps the sweep.
- Reset mid-sweep: return to IDLE immediately and zero everything; the stage-1 pipeline register is discarded.

Optional Feature:
- Macro: BSG_HISTO_TOTAL_EN.
- Defined: each channel gains a saturating total-sample counter, incremented for every accepted sample in the same stage-2 cycle as its bin. It is read at rd_bin_i = els_p+2 and zeroed as the final step of the sweep, so the sweep lasts els_p+3 cycles.
- Undefined: no total counter is built; rd_bin_i = els_p+2 reads 0; the sweep lasts els_p+2 cycles.

Test Plan:
- Ranged binning. Parameters start_p = 16, bin_shift_p = 2, els_p = 16. Channel 0 samples 16, 19, 20, 79, 80 -> bin0 = 2, bin1 = 1, bin15 = 1, overflow = 1. A sample of 15 -> underflow = 1. Channel 1 all 0.
- Latency. v_i with value 16 in cycle 10; read bin0 in cycle 11 -> 0; read in cycle 12 -> rd_v_o = 1 and rd_data_o = 1 in cycle 13.
- Saturation. ctr_width_p = 4; 20 samples of value 16 -> bin0 = 15. Both channels hit the same bin in one cycle -> each channel's count increments by 1.
- Clear. clear_i in cycle C while both channels are driving v_i -> clear_busy_o = 1 for cycles C+1 through C+18. drop_count_o increases by 2 per busy cycle plus 2 for cycle C. All bins then read 0. A clear_i at C+5 extends busy to C+23.
- Reset mid-sweep. reset_i at sweep index 7 -> next cycle clear_busy_o = 0, drop_count_o = 0, all bins read 0.
- BSG_HISTO_TOTAL_EN. 5 accepted samples plus 3 dropped -> bin els_p+2 reads 5. Without the macro, the same read returns 0.
